// File: rtl/instr_seq_exec.sv
// Instruction fetch/execute sequencer: fetches 32-bit words from a synchronous ROM,
// issues I2C bus commands over valid/ready, and runs delay, irq-wait, jump and halt.
module instr_seq_exec #(
  parameter int          ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int          DLY_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rd,
  output logic [23:0]       cmd_word,
  input  logic              cmd_done,
  input  logic              cmd_err,
  input  logic [7:0]        cmd_rdata,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              irq,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] err_pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE, S_DELAY, S_WAIT_IRQ, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_WRITE = 4'h1, OP_READ = 4'h2, OP_DELAY = 4'h3,
    OP_WAIT_IRQ = 4'h4, OP_JUMP = 4'h5, OP_HALT = 4'hF
  } op_e;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_rd_q, cmd_rd_d;
  logic [23:0]        cmd_word_q, cmd_word_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               error_q, error_d;
  logic [ADDR_W-1:0]  err_pc_q, err_pc_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               irq_s1_q, irq_s2_q;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  pc_inc;
  logic               unused_rom_bits;

  assign opcode          = rom_data[31:28];
  assign pc_inc          = pc_q + ADDR_W'(1);
  assign unused_rom_bits = ^rom_data[27:24];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cmd_valid_d = cmd_valid_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_word_d  = cmd_word_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    error_d     = error_q;
    err_pc_d    = err_pc_q;
    dly_d       = dly_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = START_PC;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          OP_WRITE, OP_READ: begin
            cmd_word_d  = rom_data[23:0];
            cmd_rd_d    = (opcode == OP_READ);
            cmd_valid_d = 1'b1;
            state_d     = S_ISSUE;
          end
          OP_DELAY: begin
            dly_d = rom_data[DLY_W-1:0];
            if (rom_data[DLY_W-1:0] == '0) begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else begin
              state_d = S_DELAY;
            end
          end
          OP_WAIT_IRQ: state_d = S_WAIT_IRQ;
          OP_JUMP: begin
            pc_d    = rom_data[ADDR_W-1:0];
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALTED;
          default: begin
            error_d  = 1'b1;
            err_pc_d = pc_q;
            state_d  = S_HALTED;
          end
        endcase
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_done) begin
          if (cmd_err) begin
            error_d  = 1'b1;
            err_pc_d = pc_q;
            state_d  = S_HALTED;
          end else begin
            if (cmd_rd_q) begin
              rd_data_d  = cmdRdataSel(cmd_rdata);
              rd_valid_d = 1'b1;
            end
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_DELAY: begin
        // <=1 rather than ==1 so a zero count can never stall the sequencer
        if (dly_q <= DLY_W'(1)) begin
          dly_d   = '0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_WAIT_IRQ: begin
        if (irq_s2_q) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [7:0] cmdRdataSel(input logic [7:0] b);
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= START_PC;
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_word_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      err_pc_q    <= '0;
      dly_q       <= '0;
      irq_s1_q    <= 1'b0;
      irq_s2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_word_q  <= cmd_word_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      error_q     <= error_d;
      err_pc_q    <= err_pc_d;
      dly_q       <= dly_d;
      irq_s1_q    <= irq;
      irq_s2_q    <= irq_s1_q;
    end
  end

  // pc is itself a flop, so it is presented to the ROM directly
  assign rom_addr  = pc_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rd    = cmd_rd_q;
  assign cmd_word  = cmd_word_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign error     = error_q;
  assign err_pc    = err_pc_q;
  assign halted    = (state_q == S_HALTED);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_instr_seq_exec.sv
// Directed bench for instr_seq_exec: behavioural sync ROM, scripted bus master,
// scoreboard queues for expected commands and read-back bytes.
module tb_instr_seq_exec;

  localparam logic [31:0] HALT = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic        cmd_valid, cmd_rd;
  logic        cmd_ready = 1'b0;
  logic [23:0] cmd_word;
  logic        cmd_done = 1'b0, cmd_err = 1'b0;
  logic [7:0]  cmd_rdata = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        irq = 1'b0;
  logic        busy, halted, error;
  logic [7:0]  err_pc;

  typedef struct packed { logic rd; logic [23:0] word; } cmd_t;
  cmd_t       exp_cmd[$];
  logic [7:0] exp_rd[$];
  logic [31:0] rom [256];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rdv   = 0;

  instr_seq_exec #(.ADDR_W(8), .START_ADDR(0), .DLY_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_word(cmd_word),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_rdata(cmd_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq), .busy(busy), .halted(halted),
    .error(error), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every rd_valid cycle must match the next queued byte; a second cycle finds the queue empty
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      n_rdv++;
      if (exp_rd.size() == 0) chk("rd_valid_unexpected", {31'b0, rd_valid}, 32'd0);
      else                    chk("rd_data", {24'b0, rd_data}, {24'b0, exp_rd.pop_front()});
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = HALT;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int t = 0;
    while (!halted && t < 200) begin @(negedge clk); t++; end
    chk(tag, {31'b0, halted}, 32'd1);
  endtask

  task automatic run_count(output int cyc);
    start_pulse();
    cyc = 0;
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
  endtask

  task automatic bus_txn(input int rdy_dly, input bit err, input logic [7:0] rdata);
    int t = 0;
    cmd_t e;
    while (!cmd_valid && t < 50) begin @(negedge clk); t++; end
    chk("cmd_valid_seen", {31'b0, cmd_valid}, 32'd1);
    if (exp_cmd.size() == 0) begin
      chk("cmd_scoreboard_empty", exp_cmd.size(), 32'd1);
      return;
    end
    e = exp_cmd.pop_front();
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) @(negedge clk);
      chk("cmd_valid_hold", {31'b0, cmd_valid}, 32'd1);
      chk("cmd_rd", {31'b0, cmd_rd}, {31'b0, e.rd});
      chk("cmd_word", {8'b0, cmd_word}, {8'b0, e.word});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("cmd_valid_drop", {31'b0, cmd_valid}, 32'd0);
    @(negedge clk);
    cmd_done = 1'b1; cmd_err = err; cmd_rdata = rdata;
    if (!err && e.rd) exp_rd.push_back(rdata);
    @(negedge clk);
    cmd_done = 1'b0; cmd_err = 1'b0; cmd_rdata = '0;
  endtask

  initial begin
    int cyc, t, rdv0;
    logic [7:0] prev;
    logic [7:0] trace[$];

    clear_rom();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_rom_addr", {24'b0, rom_addr}, 32'd0);
    chk("rst_busy_halted_err", {29'b0, busy, halted, error}, 32'd0);
    chk("rst_err_pc", {24'b0, err_pc}, 32'd0);
    chk("rst_rd", {23'b0, rd_valid, rd_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WRITE with a 3-cycle ready stall
    rom[0] = 32'h1012_3456;
    exp_cmd.push_back('{rd: 1'b0, word: 24'h123456});
    start_pulse();
    bus_txn(3, 1'b0, 8'h00);
    wait_halt("wr_halted");
    chk("wr_error", {31'b0, error}, 32'd0);
    chk("wr_rom_addr", {24'b0, rom_addr}, 32'd1);
    chk("wr_busy", {31'b0, busy}, 32'd0);

    // READ returns 0xA5
    clear_rom();
    rom[0] = 32'h2013_0000;
    exp_cmd.push_back('{rd: 1'b1, word: 24'h130000});
    rdv0 = n_rdv;
    start_pulse();
    bus_txn(1, 1'b0, 8'hA5);
    wait_halt("rd_halted");
    chk("rd_data_held", {24'b0, rd_data}, 32'h0000_00A5);
    chk("rd_valid_count", n_rdv - rdv0, 32'd1);

    // DELAY 5 vs DELAY 0: busy spans FETCH+DECODE per instruction plus the delay cycles
    clear_rom();
    rom[0] = 32'h3000_0005;
    run_count(cyc);
    chk("delay5_busy_cycles", cyc, 32'd9);
    rom[0] = 32'h3000_0000;
    run_count(cyc);
    chk("delay0_busy_cycles", cyc, 32'd4);

    // WAIT_IRQ with start ignored while waiting
    clear_rom();
    rom[0] = 32'h4000_0000;
    start_pulse();
    repeat (10) @(negedge clk);
    chk("irq_wait_busy", {31'b0, busy}, 32'd1);
    start_pulse();
    chk("irq_start_ignored_pc", {24'b0, rom_addr}, 32'd0);
    chk("irq_start_ignored_busy", {30'b0, busy, halted}, 32'd2);
    irq = 1'b1;
    t = 0;
    while (rom_addr != 8'd1 && t < 20) begin @(negedge clk); t++; end
    chk("irq_latency_2_3", {31'b0, (t >= 2 && t <= 3)}, 32'd1);
    wait_halt("irq_halted");
    run_count(cyc);
    chk("irq_high_on_entry_cycles", cyc, 32'd5);
    irq = 1'b0;

    // JUMP to 0xFF, wrap to 0x00; word at 0 becomes HALT once the jump is taken
    clear_rom();
    rom[0]   = 32'h5000_00FF;
    rom[255] = 32'h0000_0000;
    start_pulse();
    chk("jmp_start_addr", {24'b0, rom_addr}, 32'd0);
    prev = rom_addr;
    t = 0;
    while (!halted && t < 100) begin
      @(negedge clk); t++;
      if (rom_addr != prev) begin
        trace.push_back(rom_addr);
        prev = rom_addr;
        if (rom_addr == 8'hFF) rom[0] = HALT;
      end
    end
    chk("jmp_halted", {31'b0, halted}, 32'd1);
    chk("jmp_trace_len", trace.size(), 32'd2);
    if (trace.size() == 2) begin
      chk("jmp_trace0", {24'b0, trace[0]}, 32'h0000_00FF);
      chk("jmp_trace1", {24'b0, trace[1]}, 32'd0);
    end

    // illegal opcode at 3; start afterwards clears error
    clear_rom();
    rom[0] = 0; rom[1] = 0; rom[2] = 0;
    rom[3] = 32'h7000_0000;
    start_pulse();
    wait_halt("ill_halted");
    chk("ill_error", {31'b0, error}, 32'd1);
    chk("ill_err_pc", {24'b0, err_pc}, 32'd3);
    rom[3] = HALT;
    start_pulse();
    chk("ill_start_clears_error", {31'b0, error}, 32'd0);
    wait_halt("ill_rerun_halted");

    // READ NACK at pc 1
    clear_rom();
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h2013_0000;
    exp_cmd.push_back('{rd: 1'b1, word: 24'h130000});
    rdv0 = n_rdv;
    start_pulse();
    bus_txn(0, 1'b1, 8'h3C);
    wait_halt("nack_halted");
    chk("nack_error", {31'b0, error}, 32'd1);
    chk("nack_err_pc", {24'b0, err_pc}, 32'd1);
    chk("nack_no_rd_valid", n_rdv - rdv0, 32'd0);
    chk("nack_rd_data_kept", {24'b0, rd_data}, 32'h0000_00A5);

    // reset while a command is pending
    clear_rom();
    rom[0] = 32'h10AB_CDEF;
    start_pulse();
    t = 0;
    while (!cmd_valid && t < 20) begin @(negedge clk); t++; end
    chk("rstmid_cmd_word", {8'b0, cmd_word}, 32'h00AB_CDEF);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rstmid_word_rd", {7'b0, cmd_rd, cmd_word}, 32'd0);
    chk("rstmid_flags", {29'b0, busy, halted, error}, 32'd0);
    chk("rstmid_addrs", {16'b0, rom_addr, err_pc}, 32'd0);
    chk("rstmid_rd", {23'b0, rd_valid, rd_data}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {30'b0, busy, halted}, 32'd0);

    chk("sb_cmd_drained", exp_cmd.size(), 32'd0);
    chk("sb_rd_drained", exp_rd.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
